alu_issue_unit: RTL and testbench

- Initiator side of the RISCVALU operand/control interface: accepts decoded instruction fields, generates the 4-bit ALU control code, selects operand B (register or immediate), drives the ALU, captures its result and zero flag, and returns a registered result with branch resolution.
- Sits between decode and writeback; the ALU itself is external and treated as combinational, with a fixed settle window.
- Valid/ready handshakes on both the input and output sides.

---
 rtl/alu_issue_pkg.sv | 53 +++++
 rtl/alu_issue_unit_ctrl_decode.sv | 52 +++++
 rtl/alu_issue_unit.sv | 152 +++++++++++++++
 tb/tb_alu_issue_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue unit: ALU control codes, RV32I opcodes,
// FSM states and branch kinds.
package alu_issue_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_kind_e;

  // Register/immediate arithmetic code from funct3; alt picks SUB/SRA.
  function automatic logic [3:0] f3_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_unit_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7b5 into ALU control, operand
// selects, branch kind and an illegal flag.
module alu_ctrl_decode
  import alu_issue_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl,
  output logic       b_sel_imm,
  output logic       a_zero,
  output br_kind_e   branch_kind,
  output logic       illegal
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    b_sel_imm   = 1'b0;
    a_zero      = 1'b0;
    branch_kind = BR_NONE;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_ctrl = f3_code(funct3, funct7b5);
        // bit 30 only has a meaning for SUB and SRA
        if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        b_sel_imm = 1'b1;
        alu_ctrl  = f3_code(funct3, funct7b5 && (funct3 == 3'b101));
      end
      OPC_LOAD, OPC_STORE: b_sel_imm = 1'b1;
      OPC_LUI: begin
        a_zero    = 1'b1;
        b_sel_imm = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: begin alu_ctrl = ALU_SUB;  branch_kind = BR_EQ;  end
          3'b001: begin alu_ctrl = ALU_SUB;  branch_kind = BR_NE;  end
          3'b100: begin alu_ctrl = ALU_SLT;  branch_kind = BR_LT;  end
          3'b101: begin alu_ctrl = ALU_SLT;  branch_kind = BR_GE;  end
          3'b110: begin alu_ctrl = ALU_SLTU; branch_kind = BR_LTU; end
          3'b111: begin alu_ctrl = ALU_SLTU; branch_kind = BR_GEU; end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one decoded op to an external combinational ALU, waits ALU_LAT
// cycles, captures the result and resolves branches behind valid/ready.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  br_kind_e          br_q, br_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              branch_taken_q, branch_taken_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        dec_ctrl;
  logic              dec_b_imm;
  logic              dec_a_zero;
  br_kind_e          dec_br;
  logic              dec_illegal;

  alu_ctrl_decode u_decode (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_ctrl    (dec_ctrl),
    .b_sel_imm   (dec_b_imm),
    .a_zero      (dec_a_zero),
    .branch_kind (dec_br),
    .illegal     (dec_illegal)
  );

  // SLT/SLTU leave the comparison in bit 0; SUB signals equality via zero.
  function automatic logic resolve_branch(input br_kind_e k, input logic zero,
                                          input logic lsb);
    case (k)
      BR_EQ:          return zero;
      BR_NE:          return !zero;
      BR_LT, BR_LTU:  return lsb;
      BR_GE, BR_GEU:  return !lsb;
      default:        return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_ctrl_d     = alu_ctrl_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    br_d           = br_q;
    result_d       = result_q;
    branch_taken_d = branch_taken_q;
    illegal_d      = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            // ALU-facing registers are left alone so the ALU sees no change
            result_d       = '0;
            branch_taken_d = 1'b0;
            illegal_d      = 1'b1;
            br_d           = BR_NONE;
            state_d        = ST_DONE;
          end else begin
            alu_ctrl_d = dec_ctrl;
            alu_a_d    = dec_a_zero ? '0 : rs1_data;
            alu_b_d    = dec_b_imm ? imm : rs2_data;
            br_d       = dec_br;
            illegal_d  = 1'b0;
            cnt_d      = CNT_W'(ALU_LAT - 1);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          result_d       = alu_out;
          branch_taken_d = resolve_branch(br_q, alu_zero, alu_out[0]);
          state_d        = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      alu_ctrl_q     <= ALU_AND;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      br_q           <= BR_NONE;
      result_q       <= '0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_ctrl_q     <= alu_ctrl_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      br_q           <= br_d;
      result_q       <= result_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign alu_ctrl     = alu_ctrl_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign result       = result_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: external ALU model, instruction-level reference
// model checked every cycle, plus directed ops with literal expectations.
module tb_alu_issue_unit;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_unit #(.XLEN(32), .ALU_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .alu_ctrl     (alu_ctrl),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  // External ALU behaviour, keyed by the published control codes.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      4'b1000: return {31'b0, a < b};
      4'b1101: return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_out  = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero = (alu_out == 32'h0);
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // funct3 -> ALU code for register/immediate arithmetic
  localparam logic [3:0] F3CODE [8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1000,
                                        4'b0011, 4'b0101, 4'b0001, 4'b0000};

  task automatic model_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] im, output bit ill,
                              output logic [3:0] c, output logic [31:0] a,
                              output logic [31:0] b, output bit bt);
    ill = 1'b0; bt = 1'b0; a = r1; b = r2; c = 4'b0010;
    case (op)
      7'h33: begin
        c = F3CODE[f3];
        if (f7) begin
          if (f3 == 3'd0) c = 4'b0110;
          else if (f3 == 3'd5) c = 4'b1101;
          else ill = 1'b1;
        end
      end
      7'h13: begin
        c = (f3 == 3'd5 && f7) ? 4'b1101 : F3CODE[f3];
        b = im;
      end
      7'h03, 7'h23: b = im;
      7'h37: begin a = 32'h0; b = im; end
      7'h63: begin
        case (f3)
          3'd0: begin c = 4'b0110; bt = (r1 == r2); end
          3'd1: begin c = 4'b0110; bt = (r1 != r2); end
          3'd4: begin c = 4'b0111; bt = ($signed(r1) <  $signed(r2)); end
          3'd5: begin c = 4'b0111; bt = ($signed(r1) >= $signed(r2)); end
          3'd6: begin c = 4'b1000; bt = (r1 <  r2); end
          3'd7: begin c = 4'b1000; bt = (r1 >= r2); end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endtask

  bit          m_busy = 1'b0;
  bit          m_vld  = 1'b0;
  bit          m_ill  = 1'b0;
  bit          m_bt   = 1'b0;
  int          m_since = 0;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_res = '0;

  // Advance one clock, update the model from what the DUT saw at the edge,
  // then compare every output at the falling edge.
  task automatic step();
    bit acc, hs, ill, bt;
    logic [3:0]  c;
    logic [31:0] a, b;
    acc = rst && !m_busy && in_valid;
    hs  = rst && m_vld && out_ready;
    ill = 1'b0; bt = 1'b0; c = '0; a = '0; b = '0;
    if (acc) model_decode(opcode, funct3, funct7b5, rs1_data, rs2_data, imm, ill, c, a, b, bt);
    @(negedge clk);
    if (!rst) begin
      m_busy = 1'b0; m_ctrl = '0; m_a = '0; m_b = '0;
    end else if (acc) begin
      m_busy = 1'b1; m_since = 0; m_ill = ill;
      if (ill) begin
        m_res = 32'h0; m_bt = 1'b0;
      end else begin
        m_ctrl = c; m_a = a; m_b = b; m_bt = bt;
        m_res  = alu_fn(c, a, b);
      end
    end else if (hs) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_since++;
    end
    m_vld = m_busy && (m_since >= (m_ill ? 0 : LAT));
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (m_vld) begin
      chk("result", result, m_res);
      chk("branch_taken", 32'(branch_taken), 32'(m_bt));
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
  endtask

  task automatic run_op(input string nm, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input int hold, input bit keep_valid,
                        input logic [31:0] l_res, input bit l_bt, input bit l_ill,
                        input logic [3:0] l_ctrl, input logic [31:0] l_a,
                        input logic [31:0] l_b, input int l_edges);
    int waited;
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    if (keep_valid) begin
      // fields a busy unit must not sample
      opcode = 7'h7F; funct3 = 3'd2; rs1_data = 32'hDEADBEEF; imm = 32'hCAFE0000;
    end else begin
      in_valid = 1'b0;
    end
    waited = 0;
    while (!out_valid && waited < 20) begin
      step();
      waited++;
    end
    chk({nm, " latency_edges"}, 32'(waited + 1), 32'(l_edges));
    chk({nm, " result"}, result, l_res);
    chk({nm, " branch_taken"}, 32'(branch_taken), 32'(l_bt));
    chk({nm, " illegal"}, 32'(illegal), 32'(l_ill));
    if (!l_ill) begin
      chk({nm, " alu_ctrl"}, 32'(alu_ctrl), 32'(l_ctrl));
      chk({nm, " alu_a"}, alu_a, l_a);
      chk({nm, " alu_b"}, alu_b, l_b);
    end
    repeat (hold) begin
      step();
      chk({nm, " held result"}, result, l_res);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    step();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 1'b1;
    step();

    //      name    op     f3    f7    rs1           rs2           imm          hold kv  res           bt   ill  ctrl     a             b             edges
    run_op("ADD",   7'h33, 3'd0, 1'b0, 32'h11,       32'h1,        32'h0,        0, 0, 32'h12,       1'b0, 1'b0, 4'b0010, 32'h11,       32'h1,        2);
    run_op("SUB",   7'h33, 3'd0, 1'b1, 32'h11,       32'h1,        32'h0,        5, 1, 32'h10,       1'b0, 1'b0, 4'b0110, 32'h11,       32'h1,        2);
    run_op("BEQ",   7'h63, 3'd0, 1'b0, 32'h5,        32'h5,        32'h40,       0, 0, 32'h0,        1'b1, 1'b0, 4'b0110, 32'h5,        32'h5,        2);
    run_op("BNE",   7'h63, 3'd1, 1'b0, 32'h5,        32'h5,        32'h40,       0, 0, 32'h0,        1'b0, 1'b0, 4'b0110, 32'h5,        32'h5,        2);
    run_op("BGEU",  7'h63, 3'd7, 1'b0, 32'h1,        32'hFFFFFFFF, 32'h40,       0, 0, 32'h1,        1'b0, 1'b0, 4'b1000, 32'h1,        32'hFFFFFFFF, 2);
    run_op("BLT",   7'h63, 3'd4, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h40,       0, 0, 32'h1,        1'b1, 1'b0, 4'b0111, 32'hFFFFFFFF, 32'h1,        2);
    run_op("SRAI",  7'h13, 3'd5, 1'b1, 32'h80000000, 32'h7,        32'h404,      1, 0, 32'hF8000000, 1'b0, 1'b0, 4'b1101, 32'h80000000, 32'h404,      2);
    run_op("LUI",   7'h37, 3'd0, 1'b0, 32'hDEAD,     32'h3,        32'h12345000, 0, 0, 32'h12345000, 1'b0, 1'b0, 4'b0010, 32'h0,        32'h12345000, 2);
    run_op("XOR",   7'h33, 3'd4, 1'b0, 32'hF0,       32'hFF,       32'h0,        0, 0, 32'h0F,       1'b0, 1'b0, 4'b0011, 32'hF0,       32'hFF,       2);
    run_op("ILL7F", 7'h7F, 3'd0, 1'b0, 32'h1,        32'h2,        32'h3,        2, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
    run_op("BR010", 7'h63, 3'd2, 1'b0, 32'h1,        32'h2,        32'h3,        0, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
    run_op("SLLF7", 7'h33, 3'd1, 1'b1, 32'h1,        32'h2,        32'h3,        0, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
    run_op("LOAD",  7'h03, 3'd2, 1'b0, 32'h100,      32'h9,        32'hFFFFFFFC, 0, 0, 32'hFC,       1'b0, 1'b0, 4'b0010, 32'h100,      32'hFFFFFFFC, 2);

    // Streaming with out_ready high: one op per ALU_LAT+2 cycles
    opcode = 7'h33; funct3 = 3'd6; funct7b5 = 1'b0;
    rs1_data = 32'h0F00; rs2_data = 32'h00F0; imm = 32'h0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) step();

    // Asynchronous reset while an op is in ISSUE
    opcode = 7'h33; funct3 = 3'd0; funct7b5 = 1'b1;
    rs1_data = 32'h11; rs2_data = 32'h1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst result", result, 32'h0);
    chk("async rst branch_taken", 32'(branch_taken), 32'd0);
    chk("async rst illegal", 32'(illegal), 32'd0);
    chk("async rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("async rst alu_a", alu_a, 32'h0);
    chk("async rst alu_b", alu_b, 32'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
